// File: rtl/rom_boot_copier.sv
// Boot copier: after start, reads COPY_WORDS words from the boot ROM (cs_/as_/rdy_) and writes them out over req/ack.
// Define ROM_COPY_CHECKSUM_EN to add a running modulo-2^DATA_W checksum of the accepted words.
module rom_boot_copier #(
    parameter int unsigned ROM_ADDR_W = 11,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned DST_ADDR_W = 30,
    parameter int unsigned COPY_WORDS = 2048,
    parameter int unsigned ROM_BASE   = 0,
    parameter int unsigned DST_BASE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  rom_cs_,
    output logic                  rom_as_,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0]     rom_rd_data,
    input  logic                  rom_rdy_,
    output logic                  wr_req,
    output logic [DST_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_ack,
    output logic                  busy,
    output logic                  done
`ifdef ROM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0]     checksum
`endif
);

    localparam int unsigned IDX_W = $clog2(COPY_WORDS) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COPY_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_cs_n;
    logic                  r_as_n;
    logic                  r_wr_req;
    logic [DST_ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0]     r_wr_data;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_start_ok;
    logic                  w_rd_hit;
    logic                  w_wr_hit;

    always_comb begin
        w_next     = r_state;
        w_start_ok = 1'b0;
        w_rd_hit   = 1'b0;
        w_wr_hit   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next     = S_RD;
                    w_start_ok = 1'b1;
                end
            end
            S_RD: begin
                if (!rom_rdy_) begin
                    w_next   = S_WR;
                    w_rd_hit = 1'b1;
                end
            end
            S_WR: begin
                if (wr_ack) begin
                    w_wr_hit = 1'b1;
                    w_next   = (r_idx == LAST_IDX) ? S_DONE : S_RD;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Strobes and status are registered from the next state so they align with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_cs_n    <= 1'b1;
            r_as_n    <= 1'b1;
            r_wr_req  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cs_n  <= (w_next != S_RD);
            r_as_n  <= (w_next != S_RD);
            r_busy  <= (w_next == S_RD) || (w_next == S_WR);
            r_done  <= (w_next == S_DONE);
            if (w_start_ok) begin
                r_idx <= '0;
            end else if (w_wr_hit && (r_idx != LAST_IDX)) begin
                r_idx <= r_idx + IDX_W'(1);
            end
            if (w_rd_hit) begin
                r_wr_req  <= 1'b1;
                r_wr_data <= rom_rd_data;
                r_wr_addr <= DST_ADDR_W'(DST_BASE) + DST_ADDR_W'(r_idx);
            end else if (w_wr_hit) begin
                r_wr_req <= 1'b0;
            end
        end
    end

`ifdef ROM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (reset || w_start_ok) begin
            r_checksum <= '0;
        end else if (w_wr_hit) begin
            r_checksum <= r_checksum + r_wr_data;
        end
    end

    assign checksum = r_checksum;
`endif

    assign rom_cs_  = r_cs_n;
    assign rom_as_  = r_as_n;
    assign rom_addr = ROM_ADDR_W'(ROM_BASE) + ROM_ADDR_W'(r_idx);
    assign wr_req   = r_wr_req;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
